sodor_imem_responder: RTL and testbench

SODOR_IMEM_RESPONDER -- requirements
Module: sodor_imem_responder

---
 rtl/sodor_imem_responder_if.sv | 38 +++
 rtl/sodor_imem_responder.sv | 177 +++++++++++++++++
 tb/tb_sodor_imem_responder.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sodor_imem_responder_if.sv
// Fetch bus between a Sodor core and its instruction memory responder.
// The core side issues byte-addressed fetch requests and receives instruction
// words back with the address they answer and a misalignment flag.
interface sodor_imem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [31:0] resp_addr;
    logic        resp_fault;

    // Core side: issues requests, consumes responses.
    modport master (
        output req_valid,
        output req_addr,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_addr,
        input  resp_fault
    );

    // Memory side: accepts requests, produces responses.
    modport slave (
        input  req_valid,
        input  req_addr,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_addr,
        output resp_fault
    );
endinterface

// File: rtl/sodor_imem_responder.sv
// Instruction memory responder for a Sodor-style core.
// A 16-word program store answers fetch requests after a fixed LATENCY-stage
// pipeline. Responses land in a 2-entry output FIFO and leave in acceptance
// order. The in-flight plus buffered count is capped at 2, so the FIFO can
// never overflow and the pipeline never needs to stall.
module sodor_imem_responder #(
    parameter int unsigned LATENCY  = 1,             // 1..3 cycles, accept to FIFO
    parameter logic [31:0] NOP_WORD = 32'h00000013   // addi x0, x0, 0
) (
    input  logic                         clock,
    input  logic                         reset_n,
    sodor_imem_responder_if.slave        bus,
    input  logic                         prog_we,
    input  logic [3:0]                   prog_idx,
    input  logic [31:0]                  prog_data,
    output logic [1:0]                   occupancy
);

    // One response as it travels through the pipeline and the FIFO.
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
        logic        fault;
    } resp_t;

    logic [31:0] prog_mem [16];

    logic        accept;
    logic        pop;
    logic        resp_valid_int;
    resp_t       ingress;
    resp_t       push_entry;
    logic        push_valid;

    resp_t       fifo_mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  fifo_cnt;
    resp_t       head;

    logic [1:0]  occ_q;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // A pop frees a slot in the same cycle, so a full responder can still
    // accept when the core is draining it.
    assign resp_valid_int = (fifo_cnt != 2'd0);
    assign pop            = resp_valid_int && bus.resp_ready;
    assign bus.req_ready  = (occ_q < 2'd2) || pop;
    assign accept         = bus.req_valid && bus.req_ready;

    // ------------------------------------------------------------------
    // Program store
    // ------------------------------------------------------------------
    // Reset fills every word with NOP_WORD; otherwise prog_we writes one word.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            // NOTE: this store is a register array, not a RAM macro, so it can
            // be reset word by word; a real SRAM could not be initialised this way.
            for (int i = 0; i < 16; i++) begin
                prog_mem[i] <= NOP_WORD;
            end
        end else if (prog_we) begin
            prog_mem[prog_idx] <= prog_data;
        end
    end

    // Read the indexed word before this edge's write lands. The upper address
    // bits travel with the response but play no part in indexing, so fetches
    // wrap every 64 bytes.
    always_comb begin
        // NOTE: every field is assigned on every pass, so no latch can form.
        ingress.data  = prog_mem[bus.req_addr[5:2]];
        ingress.addr  = bus.req_addr;
        ingress.fault = (bus.req_addr[1:0] != 2'b00);
    end

    // ------------------------------------------------------------------
    // Latency pipeline
    // ------------------------------------------------------------------
    generate
        if (LATENCY <= 1) begin : g_direct
            // With a single cycle of latency the read word goes straight into the FIFO.
            always_comb begin
                push_valid = accept;
                push_entry = ingress;
            end
        end else begin : g_pipe
            logic [LATENCY-2:0] stage_valid;
            resp_t              stage_q [LATENCY-1];

            // Delay line of LATENCY-1 registers; only the valid bits need reset.
            always_ff @(posedge clock) begin
                // NOTE: state registers use non-blocking assignments so every
                // stage samples its neighbour's pre-edge value.
                if (!reset_n) begin
                    stage_valid <= '0;
                end else begin
                    for (int i = LATENCY - 2; i > 0; i--) begin
                        stage_valid[i] <= stage_valid[i-1];
                    end
                    stage_valid[0] <= accept;
                end
                for (int i = LATENCY - 2; i > 0; i--) begin
                    stage_q[i] <= stage_q[i-1];
                end
                stage_q[0] <= ingress;
            end

            // The last delay stage feeds the FIFO write port.
            always_comb begin
                push_valid = stage_valid[LATENCY-2];
                push_entry = stage_q[LATENCY-2];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output FIFO (2 entries)
    // ------------------------------------------------------------------
    // Pointers and fill count; a reset discards everything still buffered.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push_valid) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_valid, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO payload storage; contents are meaningless while the count says empty.
    always_ff @(posedge clock) begin
        if (push_valid) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    assign head = fifo_mem[rd_ptr];

    // The head only moves on a pop, so a stalled response holds steady. When
    // nothing is buffered the payload is forced to zero to hide stale entries.
    assign bus.resp_valid = resp_valid_int;
    assign bus.resp_data  = resp_valid_int ? head.data  : 32'd0;
    assign bus.resp_addr  = resp_valid_int ? head.addr  : 32'd0;
    assign bus.resp_fault = resp_valid_int ? head.fault : 1'b0;

    // ------------------------------------------------------------------
    // Occupancy: responses in flight plus buffered
    // ------------------------------------------------------------------
    // Count up on accept and down on pop; both together leave it unchanged.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            occ_q <= 2'd0;
        end else begin
            case ({accept, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_sodor_imem_responder.sv
// Self-checking bench for sodor_imem_responder (LATENCY = 1).
// A negedge monitor keeps a reference program store and a queue of expected
// responses. It pushes an entry when a request is accepted and pops/compares
// when a response is consumed. Scenario tasks add direct checks of their own.
module tb_sodor_imem_responder;

    localparam int unsigned LATENCY = 1;
    localparam logic [31:0] NOP     = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_idx = 4'd0;
    logic [31:0] prog_data = 32'd0;
    logic [1:0]  occupancy;

    sodor_imem_responder_if bus();

    sodor_imem_responder #(
        .LATENCY  (LATENCY),
        .NOP_WORD (NOP)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .prog_we   (prog_we),
        .prog_idx  (prog_idx),
        .prog_data (prog_data),
        .occupancy (occupancy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        logic        fault;
        int          due;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] m_mem [16];
    int          m_occ = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    int          n_compared = 0;
    int          n_mismatched = 0;

    always @(posedge clock) cyc++;

    // Reference model and scoreboard, evaluated half a cycle before each edge.
    always @(negedge clock) begin
        if (!reset_n) begin
            sb_q.delete();
            m_occ = 0;
            for (int i = 0; i < 16; i++) m_mem[i] = NOP;
        end else if (mon_en) begin
            bit   exp_valid;
            bit   exp_pop;
            bit   exp_ready;
            bit   exp_acc;
            exp_t e;
            exp_valid = (sb_q.size() > 0) && (sb_q[0].due <= cyc);
            n_compared++;
            if (bus.resp_valid !== exp_valid) begin
                n_mismatched++;
                $display("FAIL sb_resp_valid @%0d: got %b expected %b", cyc, bus.resp_valid, exp_valid);
            end
            if (exp_valid) begin
                n_compared++;
                if (bus.resp_data !== sb_q[0].data || bus.resp_addr !== sb_q[0].addr ||
                    bus.resp_fault !== sb_q[0].fault) begin
                    n_mismatched++;
                    $display("FAIL sb_payload @%0d: got %h/%h/%b expected %h/%h/%b", cyc,
                             bus.resp_data, bus.resp_addr, bus.resp_fault,
                             sb_q[0].data, sb_q[0].addr, sb_q[0].fault);
                end
            end
            exp_pop   = exp_valid && (bus.resp_ready === 1'b1);
            exp_ready = (m_occ < 2) || exp_pop;
            n_compared++;
            if (bus.req_ready !== exp_ready) begin
                n_mismatched++;
                $display("FAIL sb_req_ready @%0d: got %b expected %b", cyc, bus.req_ready, exp_ready);
            end
            n_compared++;
            if (occupancy !== 2'(m_occ)) begin
                n_mismatched++;
                $display("FAIL sb_occupancy @%0d: got %0d expected %0d", cyc, occupancy, m_occ);
            end
            if (exp_pop) void'(sb_q.pop_front());
            exp_acc = (bus.req_valid === 1'b1) && exp_ready;
            if (exp_acc) begin
                e.data  = m_mem[bus.req_addr[5:2]];
                e.addr  = bus.req_addr;
                e.fault = (bus.req_addr[1:0] != 2'b00);
                e.due   = cyc + int'(LATENCY);
                sb_q.push_back(e);
            end
            m_occ = m_occ + (exp_acc ? 1 : 0) - (exp_pop ? 1 : 0);
            if (prog_we) m_mem[prog_idx] = prog_data;
        end
    end

    // Offer one request until it is accepted; returns one tick after the accepting edge.
    task automatic fetch(input logic [31:0] addr);
        int   budget = 0;
        logic acc = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        while (!acc && budget < 50) begin
            @(negedge clock);
            acc = bus.req_ready;
            @(posedge clock);
            #1;
            budget++;
        end
        bus.req_valid = 1'b0;
        n_compared++;
        if (acc !== 1'b1) begin
            n_mismatched++;
            $display("FAIL fetch_timeout: addr %h accepted=%b required 1", addr, acc);
        end
    endtask

    // Write one program word over a single edge.
    task automatic prog_write(input logic [3:0] idx, input logic [31:0] data);
        prog_we   = 1'b1;
        prog_idx  = idx;
        prog_data = data;
        @(posedge clock);
        #1;
        prog_we = 1'b0;
    endtask

    task automatic test_reset();
        // Hostile inputs during reset must be ignored.
        reset_n       = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h4;
        prog_we       = 1'b1;
        prog_idx      = 4'd1;
        prog_data     = 32'hBAD0BAD0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_compared++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_fault, occupancy} !== 5'b10000) begin
            n_mismatched++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b flt=%b occ=%0d expected 1/0/0/0",
                     bus.req_ready, bus.resp_valid, bus.resp_fault, occupancy);
        end
        n_compared++;
        if (bus.resp_data !== 32'd0 || bus.resp_addr !== 32'd0) begin
            n_mismatched++;
            $display("FAIL reset_data: got %h/%h expected 0/0", bus.resp_data, bus.resp_addr);
        end
        @(posedge clock);
        #1;
        reset_n       = 1'b1;
        bus.req_valid = 1'b0;
        prog_we       = 1'b0;
        mon_en        = 1'b1;
        @(negedge clock);
        n_compared++;
        if ({bus.req_ready, bus.resp_valid, occupancy} !== 4'b1000 || bus.resp_data !== 32'd0) begin
            n_mismatched++;
            $display("FAIL after_reset: got rdy=%b vld=%b occ=%0d data=%h expected 1/0/0/0",
                     bus.req_ready, bus.resp_valid, occupancy, bus.resp_data);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic_fetch();
        fetch(32'h4);
        @(negedge clock);
        n_compared++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== NOP || bus.resp_addr !== 32'h4 ||
            bus.resp_fault !== 1'b0) begin
            n_mismatched++;
            $display("FAIL basic_fetch: got %b %h %h %b expected 1 %h 00000004 0",
                     bus.resp_valid, bus.resp_data, bus.resp_addr, bus.resp_fault, NOP);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_wrap();
        prog_write(4'd1, 32'h06400083);
        fetch(32'h4);
        @(negedge clock);
        n_compared++;
        if (bus.resp_data !== 32'h06400083) begin
            n_mismatched++;
            $display("FAIL wrap_0x4: got %h expected 06400083", bus.resp_data);
        end
        @(posedge clock);
        #1;
        fetch(32'h44);
        @(negedge clock);
        n_compared++;
        if (bus.resp_data !== 32'h06400083 || bus.resp_addr !== 32'h44) begin
            n_mismatched++;
            $display("FAIL wrap_0x44: got %h/%h expected 06400083/00000044", bus.resp_data, bus.resp_addr);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_same_cycle_write();
        prog_we       = 1'b1;
        prog_idx      = 4'd2;
        prog_data     = 32'hDEADBEEF;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8;
        @(negedge clock);
        n_compared++;
        if (bus.req_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL same_cycle_ready: got %b expected 1", bus.req_ready);
        end
        @(posedge clock);
        #1;
        prog_we       = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clock);
        n_compared++;
        if (bus.resp_data !== NOP) begin
            n_mismatched++;
            $display("FAIL same_cycle_old: got %h expected %h", bus.resp_data, NOP);
        end
        @(posedge clock);
        #1;
        fetch(32'h8);
        @(negedge clock);
        n_compared++;
        if (bus.resp_data !== 32'hDEADBEEF) begin
            n_mismatched++;
            $display("FAIL same_cycle_new: got %h expected deadbeef", bus.resp_data);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_fault();
        fetch(32'h6);
        @(negedge clock);
        n_compared++;
        if (bus.resp_fault !== 1'b1 || bus.resp_data !== 32'h06400083 || bus.resp_addr !== 32'h6) begin
            n_mismatched++;
            $display("FAIL misaligned: got %b/%h/%h expected 1/06400083/00000006",
                     bus.resp_fault, bus.resp_data, bus.resp_addr);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_backpressure();
        prog_write(4'd4, 32'h11111111);
        prog_write(4'd5, 32'h22222222);
        prog_write(4'd6, 32'h33333333);
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h10;
        @(negedge clock);
        @(posedge clock);
        #1;
        bus.req_addr = 32'h14;
        @(negedge clock);
        @(posedge clock);
        #1;
        bus.req_addr = 32'h18;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_compared++;
            if (bus.req_ready !== 1'b0 || occupancy !== 2'd2 || bus.resp_valid !== 1'b1 ||
                bus.resp_data !== 32'h11111111) begin
                n_mismatched++;
                $display("FAIL full_hold[%0d]: got rdy=%b occ=%0d vld=%b data=%h expected 0/2/1/11111111",
                         i, bus.req_ready, occupancy, bus.resp_valid, bus.resp_data);
            end
            @(posedge clock);
            #1;
        end
        bus.resp_ready = 1'b1;
        @(negedge clock);
        n_compared++;
        if (bus.req_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL first_pop_accept: got req_ready %b expected 1", bus.req_ready);
        end
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        n_compared++;
        if (bus.resp_data !== 32'h22222222 || occupancy !== 2'd2) begin
            n_mismatched++;
            $display("FAIL drain_second: got %h occ=%0d expected 22222222 occ=2", bus.resp_data, occupancy);
        end
        @(posedge clock);
        #1;
        @(negedge clock);
        n_compared++;
        if (bus.resp_data !== 32'h33333333 || occupancy !== 2'd1) begin
            n_mismatched++;
            $display("FAIL drain_third: got %h occ=%0d expected 33333333 occ=1", bus.resp_data, occupancy);
        end
        @(posedge clock);
        #1;
        @(negedge clock);
        n_compared++;
        if (bus.resp_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_mismatched++;
            $display("FAIL drain_empty: got vld=%b occ=%0d expected 0/0", bus.resp_valid, occupancy);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_back_to_back();
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.req_addr = 32'(i * 4);
            @(negedge clock);
            n_compared++;
            if (bus.req_ready !== 1'b1 || (i > 0 && bus.resp_valid !== 1'b1)) begin
                n_mismatched++;
                $display("FAIL b2b[%0d]: got rdy=%b vld=%b expected 1/%0d", i, bus.req_ready,
                         bus.resp_valid, (i > 0) ? 1 : 0);
            end
            @(posedge clock);
            #1;
        end
        bus.req_valid = 1'b0;
        @(negedge clock);
        n_compared++;
        if (bus.resp_valid !== 1'b1 || bus.resp_addr !== 32'h1C) begin
            n_mismatched++;
            $display("FAIL b2b_last: got vld=%b addr=%h expected 1/0000001c", bus.resp_valid, bus.resp_addr);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid();
        bus.resp_ready = 1'b0;
        fetch(32'h10);
        fetch(32'h14);
        @(negedge clock);
        n_compared++;
        if (occupancy !== 2'd2) begin
            n_mismatched++;
            $display("FAIL pre_reset_occ: got %0d expected 2", occupancy);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n        = 1'b1;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_compared++;
            if (bus.resp_valid !== 1'b0 || occupancy !== 2'd0) begin
                n_mismatched++;
                $display("FAIL post_reset[%0d]: got vld=%b occ=%0d expected 0/0", i, bus.resp_valid, occupancy);
            end
            @(posedge clock);
            #1;
        end
        fetch(32'h10);
        @(negedge clock);
        n_compared++;
        if (bus.resp_data !== NOP) begin
            n_mismatched++;
            $display("FAIL post_reset_store: got %h expected %h", bus.resp_data, NOP);
        end
        @(posedge clock);
        #1;
        fetch(32'h8);
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'd0;
        bus.resp_ready = 1'b1;
        test_reset();
        test_basic_fetch();
        test_wrap();
        test_same_cycle_write();
        test_fault();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_compared++;
        if (sb_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL leftover_responses: got %0d outstanding expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // Hard stop so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
